ext_aw_arbiter_ipa: RTL and testbench

//   Round-robin arbiter sharing one AXI AW channel (feeding ext_aw_buffer_ipa) between N_MST requesters.

---
 rtl/ext_aw_arbiter_ipa.sv | 144 ++++++++++++++
 tb/tb_ext_aw_arbiter_ipa.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ext_aw_arbiter_ipa.sv
// Round-robin arbiter that shares one AXI AW channel between N_MST requesters.
// It keeps an in-order W-route FIFO and prepends the requester index to the outgoing ID.
module ext_aw_arbiter_ipa #(
    parameter int N_MST      = 4,
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int USER_WIDTH = 6,
    parameter int WQ_DEPTH   = 4,
    parameter int IW         = $clog2(N_MST),
    parameter int PW         = 29 + ADDR_WIDTH + USER_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_MST-1:0]          slave_valid_i,
    input  logic [N_MST*PW-1:0]       slave_payload_i,
    input  logic [N_MST*ID_WIDTH-1:0] slave_id_i,
    output logic [N_MST-1:0]          slave_ready_o,
    output logic                      master_valid_o,
    output logic [PW-1:0]             master_payload_o,
    output logic [IW+ID_WIDTH-1:0]    master_id_o,
    input  logic                      master_ready_i,
    output logic [IW-1:0]             w_sel_o,
    output logic                      w_sel_valid_o,
    input  logic                      w_last_done_i,
    output logic                      w_pop_err_o
);
    localparam int QW = $clog2(WQ_DEPTH);
    localparam int CW = QW + 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              r_state;
    logic [IW-1:0]       r_grant;
    logic [IW-1:0]       r_rr_ptr;
    logic [IW-1:0]       r_fifo [WQ_DEPTH];
    logic [QW-1:0]       r_wr_ptr;
    logic [QW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;

    logic                w_any;
    logic [IW-1:0]       w_winner;
    logic [IW-1:0]       w_cand;
    logic                w_push;
    logic                w_pop;
    logic                w_empty;
    logic                w_space;

    function automatic logic [IW-1:0] f_next_idx(input logic [IW-1:0] idx);
        if (idx == IW'(N_MST - 1)) begin
            return '0;
        end else begin
            return idx + IW'(1);
        end
    endfunction

    assign w_empty = (r_count == CW'(0));
    assign w_space = (r_count < CW'(WQ_DEPTH));
    assign w_push  = (r_state == ST_LOCKED) && master_ready_i;
    assign w_pop   = w_last_done_i && !w_empty;

    // Cyclic search for the first valid requester at or after the round-robin pointer.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int i = 0; i < N_MST; i++) begin
            w_cand = IW'((int'(r_rr_ptr) + i) % N_MST);
            if (!w_any && slave_valid_i[w_cand]) begin
                w_any    = 1'b1;
                w_winner = w_cand;
            end else begin
                w_any    = w_any;
            end
        end
    end

    // Arbitration FSM: the grant is held from selection until the AW handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any && w_space) begin
                        r_grant <= w_winner;
                        r_state <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (master_ready_i) begin
                        r_rr_ptr <= f_next_idx(r_grant);
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // W-route FIFO; at most one grant is in flight, so a push cannot overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= r_grant;
                r_wr_ptr         <= r_wr_ptr + QW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + QW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Only the locked requester sees AWREADY.
    always_comb begin
        slave_ready_o = '0;
        if (r_state == ST_LOCKED) begin
            slave_ready_o[r_grant] = master_ready_i;
        end else begin
            slave_ready_o = '0;
        end
    end

    assign master_valid_o   = (r_state == ST_LOCKED);
    assign master_payload_o = slave_payload_i[int'(r_grant)*PW +: PW];
    assign master_id_o      = {r_grant, slave_id_i[int'(r_grant)*ID_WIDTH +: ID_WIDTH]};
    assign w_sel_o          = w_empty ? '0 : r_fifo[r_rd_ptr];
    assign w_sel_valid_o    = !w_empty;
    assign w_pop_err_o      = w_last_done_i && w_empty;

endmodule

// File: tb/tb_ext_aw_arbiter_ipa.sv
// Table-driven bench for ext_aw_arbiter_ipa: one row per clock cycle,
// holding that cycle's inputs and the outputs expected before its clock edge.
module tb_ext_aw_arbiter_ipa;
    localparam int N  = 4;
    localparam int IDW = 4;
    localparam int PW = 29 + 32 + 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      valid;
    logic [N*PW-1:0]   pay_bus;
    logic [N*IDW-1:0]  id_bus;
    logic [N-1:0]      sready;
    logic              mvalid;
    logic [PW-1:0]     mpay;
    logic [2+IDW-1:0]  mid;
    logic              mready;
    logic [1:0]        wsel;
    logic              wselv;
    logic              wdone;
    logic              perr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ext_aw_arbiter_ipa dut (
        .clk_i(clk), .rst_i(rst),
        .slave_valid_i(valid), .slave_payload_i(pay_bus), .slave_id_i(id_bus),
        .slave_ready_o(sready), .master_valid_o(mvalid), .master_payload_o(mpay),
        .master_id_o(mid), .master_ready_i(mready),
        .w_sel_o(wsel), .w_sel_valid_o(wselv), .w_last_done_i(wdone),
        .w_pop_err_o(perr)
    );

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic       rdy;
        logic       wd;
        logic       mv;
        logic [3:0] sr;
        logic [1:0] g;
        logic [1:0] ws;
        logic       wsv;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [PW-1:0] pay(input int k);
        return {3'b101, 32'hDEAD_BE00 + 32'(k), 32'h0F0F_0000 + 32'(k)};
    endfunction

    function automatic logic [IDW-1:0] idv(input int k);
        return IDW'(k + 5);
    endfunction

    task automatic chk(input string nm, input int row, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
        end
    endtask

    initial begin
        bit seen;
        for (int k = 0; k < N; k++) begin
            pay_bus[k*PW +: PW]  = pay(k);
            id_bus[k*IDW +: IDW] = idv(k);
        end
        rst = 1'b1; valid = 4'b0000; mready = 1'b0; wdone = 1'b0;
        @(posedge clk);

        //                rst   v        rdy   wd    mv    sr       g      ws     wsv   err
        tbl.push_back('{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0}); // 0 reset
        tbl.push_back('{1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0}); // 1 req2 only
        tbl.push_back('{1'b0, 4'b0100, 1'b1, 1'b0, 1'b1, 4'b0100, 2'd2, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd2, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd0, 2'd2, 1'b1, 1'b0}); // pop
        tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0, 1'b0, 1'b1}); // 5 pop empty
        tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0}); // 7 reset rr
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0, 1'b1, 1'b0}); // 10
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0010, 2'd1, 2'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0100, 2'd2, 2'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b1000, 2'd3, 2'd0, 1'b1, 1'b0}); // 15 fourth push
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0, 1'b1, 1'b0}); // full
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0010, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0, 1'b1, 1'b0}); // pop frees slot
        tbl.push_back('{1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd1, 1'b1, 1'b0}); // 20
        tbl.push_back('{1'b0, 4'b0010, 1'b1, 1'b0, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd0, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd0, 2'd2, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd3, 1'b1, 1'b0}); // 24 req0
        for (int i = 0; i < 5; i++)
            tbl.push_back('{1'b0, 4'b1001, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd0, 2'd3, 1'b1, 1'b0}); // stall
        tbl.push_back('{1'b0, 4'b1001, 1'b1, 1'b0, 1'b1, 4'b0001, 2'd0, 2'd3, 1'b1, 1'b0}); // 30
        tbl.push_back('{1'b0, 4'b1001, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd0, 2'd3, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b1001, 1'b1, 1'b1, 1'b1, 4'b1000, 2'd3, 2'd1, 1'b1, 1'b0}); // push+pop at 2
        tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd0, 2'd3, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0, 1'b0, 1'b1}); // 35
        tbl.push_back('{1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0010, 1'b1, 1'b0, 1'b1, 4'b0010, 2'd1, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 4'b0110, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd2, 2'd1, 1'b1, 1'b0}); // reset while locked
        tbl.push_back('{1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0}); // 40
        tbl.push_back('{1'b0, 4'b0110, 1'b1, 1'b0, 1'b1, 4'b0010, 2'd1, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd1, 1'b1, 1'b0});

        foreach (tbl[r]) begin
            #1;
            rst = tbl[r].rst; valid = tbl[r].v; mready = tbl[r].rdy; wdone = tbl[r].wd;
            @(negedge clk);
            chk("master_valid", r, 128'(mvalid), 128'(tbl[r].mv));
            chk("slave_ready", r, 128'(sready), 128'(tbl[r].sr));
            if (tbl[r].mv) begin
                chk("master_id", r, 128'(mid), 128'({tbl[r].g, idv(int'(tbl[r].g))}));
                chk("master_payload", r, 128'(mpay), 128'(pay(int'(tbl[r].g))));
            end
            chk("w_sel", r, 128'(wsel), 128'(tbl[r].ws));
            chk("w_sel_valid", r, 128'(wselv), 128'(tbl[r].wsv));
            chk("w_pop_err", r, 128'(perr), 128'(tbl[r].err));
            @(posedge clk);
        end

        // Bounded wait: req0 alone must be granted with rr_ptr at 2.
        #1;
        valid = 4'b0001; mready = 1'b1; wdone = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            if (mvalid) begin
                seen = 1'b1;
                chk("late_id", 100, 128'(mid), 128'({2'd0, idv(0)}));
                chk("late_ready", 100, 128'(sready), 128'(4'b0001));
                chk("late_payload", 100, 128'(mpay), 128'(pay(0)));
            end
            @(posedge clk);
            #1;
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL late_grant_timeout: got no master_valid, expected one within 8 cycles");
        end
        valid = 4'b0000; mready = 1'b0;
        @(negedge clk);
        chk("late_wsel", 101, 128'(wsel), 128'(2'd1));
        chk("late_wselv", 101, 128'(wselv), 128'(1'b1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
